// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the parity helper used by
// both uart_tx and uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Widest data field the parity helper accepts; narrower words are zero-extended,
  // which leaves their XOR reduction unchanged.
  localparam int MAX_DATA_BITS = 16;

  localparam logic SYNC_IDLE_LEVEL = 1'b1;

  // Parity bit a transmitter appends: even -> ^data, odd -> ~^data.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic                     odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both stages reset to
// RESET_VAL so the output starts at the line's idle level.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1/8E1/8O1 frame recovery with a valid/ready byte
// output carrying parity, framing and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 oversample_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_q,      state_d;
  logic [CNT_W-1:0]     tick_cnt_q,   tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,      shreg_d;
  logic                 perr_q,       perr_d;
  logic                 armed_q,      armed_d;
  logic                 out_valid_q,  out_valid_d;
  logic [DATA_BITS-1:0] out_data_q,   out_data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 overrun_q,    overrun_d;

  logic last_tick;
  logic frame_done;
  logic ferr_now;

  uart_sync2 #(
    .RESET_VAL(SYNC_IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  assign last_tick = (tick_cnt_q == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      armed_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      armed_q      <= armed_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next state: everything advances only on oversample ticks. The tick counter
  // wraps from OVERSAMPLE-1 to 0 on its own because OVERSAMPLE is a power of two.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    armed_d    = armed_q;

    if (oversample_tick) begin
      if (rx_s) begin
        armed_d = 1'b1;
      end
      tick_cnt_d = tick_cnt_q + CNT_W'(1);

      unique case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (armed_q && !rx_s) begin
            state_d = START;
          end
        end
        START: begin
          if (tick_cnt_q == MID_START) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (last_tick) begin
            shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              perr_d  = 1'b0;
              state_d = parity_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (last_tick) begin
            perr_d  = rx_s ^ parity_bit(MAX_DATA_BITS'(shreg_q), parity_odd);
            state_d = STOP;
          end
        end
        STOP: begin
          // A low stop bit (break) disarms so a held-low line yields one byte only.
          if (last_tick) begin
            state_d = IDLE;
            if (!rx_s) begin
              armed_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs: a completed frame loads unless a held byte is still unaccepted, in
  // which case the new byte is dropped and overrun pulses.
  always_comb begin
    busy         = (state_q != IDLE);
    frame_done   = oversample_tick && (state_q == STOP) && last_tick;
    ferr_now     = ~rx_s;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d  = 1'b1;
        out_data_d   = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_now;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames bit by bit at 16x oversampling and
// checks delivered bytes against an expected-result queue.
module tb_uart_rx;

  localparam int TICK_DIV = 27;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       oversample_tick = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ov_cnt = 0;
  bit   saw_busy = 1'b0;
  int   div = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  uart_rx #(
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .oversample_tick(oversample_tick),
    .rx             (rx),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (div == TICK_DIV - 1) begin
      div             <= 0;
      oversample_tick <= 1'b1;
    end else begin
      div             <= div + 1;
      oversample_tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back({out_data, parity_err, frame_err});
    if (overrun) ov_cnt++;
    if (busy) saw_busy = 1'b1;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit,
                            input logic stopb);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stopb;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_got(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (got_q.size() > 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_hold: outputs %b, required all 0",
               {out_valid, out_data, parity_err, frame_err, overrun, busy});
    end
    reset = 1'b0;
    wait_bits(1);
    n_cmp++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_idle: outputs %b, required all 0",
               {out_valid, out_data, parity_err, frame_err, overrun, busy});
    end
  endtask

  task automatic test_loopback();
    rec_t e, g;
    bit   ok;
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    out_ready  = 1'b1;
    exp_q.push_back({8'h41, 1'b0, 1'b0});
    send_frame(8'h41, 1'b1, 1'b0, 1'b1);
    rx = 1'b1;
    e = exp_q.pop_front();
    wait_got(4 * BIT_CLKS, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL loopback_frame: no byte delivered, required d=%h", e.d);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL loopback_frame: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 g.d, g.pe, g.fe, e.d, e.pe, e.fe);
      end
    end
    wait_bits(1);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL loopback_single: extra bytes %0d, required 0", got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_parity();
    rec_t e, g;
    bit   ok;
    for (int k = 0; k < 2; k++) begin
      parity_en  = 1'b1;
      parity_odd = (k == 1);
      // 0x41 has even weight: p=1 is wrong for even parity, right for odd parity
      exp_q.push_back({8'h41, (k == 0), 1'b0});
      send_frame(8'h41, 1'b1, 1'b1, 1'b1);
      rx = 1'b1;
      e = exp_q.pop_front();
      wait_got(4 * BIT_CLKS, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL parity_%0d: no byte delivered, required pe=%b", k, e.pe);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL parity_%0d: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                   k, g.d, g.pe, g.fe, e.d, e.pe, e.fe);
        end
      end
      wait_bits(1);
    end
  endtask

  task automatic test_break();
    rec_t e, g;
    parity_en = 1'b0;
    exp_q.push_back({8'hA5, 1'b0, 1'b1});
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_bits(10);
    e = exp_q.pop_front();
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++;
      $display("FAIL break_count: %0d bytes while line low, required 1", got_q.size());
    end
    n_cmp++;
    if (got_q.size() == 0) begin
      n_err++;
      $display("FAIL break_frame: no byte delivered, required d=%h fe=1", e.d);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL break_frame: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 g.d, g.pe, g.fe, e.d, e.pe, e.fe);
      end
    end
    got_q.delete();
    rx = 1'b1;
    wait_bits(2);
    n_cmp++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL break_recover: bytes=%0d busy=%b, required 0 and 0", got_q.size(), busy);
      got_q.delete();
    end
  endtask

  task automatic test_glitch();
    saw_busy = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    n_cmp++;
    if (saw_busy !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_start: busy seen=%b, required 1", saw_busy);
    end
    n_cmp++;
    if (busy !== 1'b0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_reject: busy=%b bytes=%0d, required 0 and 0", busy, got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, g;
    bit   ok;
    parity_en = 1'b0;
    out_ready = 1'b0;
    ov_cnt    = 0;
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    wait_bits(1);
    n_cmp++;
    if (ov_cnt != 1) begin
      n_err++;
      $display("FAIL b2b_overrun: overrun high for %0d clks, required 1", ov_cnt);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_err++;
      $display("FAIL b2b_hold: valid=%b data=%h, required 1 and 11", out_valid, out_data);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_noaccept: %0d bytes accepted, required 0", got_q.size());
      got_q.delete();
    end
    @(negedge clk);
    out_ready = 1'b1;
    e = exp_q.pop_front();
    wait_got(BIT_CLKS, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL b2b_frame: no byte accepted, required d=%h", e.d);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL b2b_frame: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 g.d, g.pe, g.fe, e.d, e.pe, e.fe);
      end
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || got_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain: valid=%b extra=%0d, required 0 and 0", out_valid, got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    rec_t       e, g;
    bit         ok;
    logic [7:0] partial;
    parity_en = 1'b0;
    out_ready = 1'b1;
    partial   = 8'h5A;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      rx = partial[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = partial[7];
    repeat (BIT_CLKS / 4) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_busy: busy=%b before reset, required 1", busy);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL midreset_clear: outputs %b, required all 0",
               {out_valid, out_data, parity_err, frame_err, overrun, busy});
    end
    // Release just after a tick so the synchronizer settles before the next one.
    ok = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV && !ok; i++) begin
      @(negedge clk);
      ok = oversample_tick;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (BIT_CLKS / 4) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    n_cmp++;
    if ({out_valid, out_data, parity_err, frame_err, overrun, busy} !== 13'd0 ||
        got_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_nobyte: outputs %b bytes=%0d, required all 0 and 0",
               {out_valid, out_data, parity_err, frame_err, overrun, busy}, got_q.size());
      got_q.delete();
    end
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    e = exp_q.pop_front();
    wait_got(4 * BIT_CLKS, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL midreset_next: no byte delivered, required d=%h", e.d);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        n_err++;
        $display("FAIL midreset_next: got d=%h pe=%b fe=%b, required d=%h pe=%b fe=%b",
                 g.d, g.pe, g.fe, e.d, e.pe, e.fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_parity();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    wait_bits(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
